// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receive stage:
// output FSM state encoding and the bit-counter width helper.
package sipo_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // A 1-bit counter is still needed for the smallest legal word (2 bits).
    function automatic int CNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/dff_en_clr.sv
// Single-bit D flip-flop with async active-low reset, synchronous clear
// (dominant over enable) and clock enable. One link of the shift chain.
module dff_en_clr (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sipo_shift_register.sv
// Serial-in/parallel-out receiver: collects WIDTH qualified bits MSB-first and
// offers each completed word on a valid/ready output with a sticky overrun flag.
module sipo_shift_register
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clear,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    localparam int             CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_overrun;
    logic             r_state;
    logic             w_next_state;
    logic             w_load;
    logic             w_ovr_set;

    // The next shift value doubles as the completed word on the final bit.
    assign w_word     = {w_sr[WIDTH-2:0], din};
    assign w_complete = din_valid && (r_cnt == CNT_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        dff_en_clr u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (sync_clear),
            .i_en  (din_valid),
            .i_d   (w_word[i]),
            .o_q   (w_sr[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sync_clear) begin
            r_cnt <= '0;
        end else if (din_valid) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else if (sync_clear) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A completion while FULL replaces dout only if the old word leaves this edge.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_next_state = ST_FULL;
                    w_load       = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_complete && dout_ready) begin
                    w_load = 1'b1;
                end else if (w_complete) begin
                    w_ovr_set = 1'b1;
                end else if (dout_ready) begin
                    w_next_state = ST_EMPTY;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= '0;
            r_overrun <= 1'b0;
        end else if (sync_clear) begin
            r_dout    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_dout <= w_word;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = (r_state == ST_FULL);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_shift_register.sv
// Directed bench for sipo_shift_register (WIDTH=8): words expected at the
// output are queued when driven and checked when the handshake takes them.
module tb_sipo_shift_register;

    logic       clk;
    logic       rst_n;
    logic       sync_clear;
    logic       din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overrun;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    sipo_shift_register #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clear (sync_clear),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock; a handshake visible at the falling edge is scored before it lands.
    task automatic tick();
        @(negedge clk);
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk8("sb_unexpected_word", dout, 8'hxx);
            end else begin
                exp_w = exp_q.pop_front();
                chk8("sb_word", dout, exp_w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_msbs(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(w[i]);
    endtask

    // Sends a word into an empty output stage, checking dout_valid rises only on the last bit.
    task automatic send_word_chk(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            chk1("vld_per_bit", dout_valid, (i == 0));
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk1("vld_in_gap", dout_valid, 1'b0);
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sync_clear = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        chk8("rst_dout", dout, 8'h00);
        chk1("rst_vld", dout_valid, 1'b0);
        chk1("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        tick();

        // single word, consumer always ready
        dout_ready = 1'b1;
        exp_q.push_back(8'hB2);
        send_word_chk(8'hB2, 0);
        chk8("single_dout", dout, 8'hB2);
        chk1("single_ovr", overrun, 1'b0);
        tick();
        chk1("single_vld_one_cycle", dout_valid, 1'b0);

        // gapped input
        exp_q.push_back(8'hB2);
        send_word_chk(8'hB2, 3);
        chk8("gap_dout", dout, 8'hB2);
        tick();
        chk1("gap_vld_drop", dout_valid, 1'b0);

        // stall and overrun
        dout_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_msbs(8'h5A, 8);
        chk1("stall_vld", dout_valid, 1'b1);
        chk8("stall_dout", dout, 8'h5A);
        chk1("stall_ovr_pre", overrun, 1'b0);
        send_msbs(8'hC3, 8);
        chk8("ovr_dout_kept", dout, 8'h5A);
        chk1("ovr_set", overrun, 1'b1);
        chk1("ovr_vld", dout_valid, 1'b1);
        dout_ready = 1'b1;
        tick();
        chk1("ovr_drain_vld", dout_valid, 1'b0);
        chk1("ovr_sticky", overrun, 1'b1);

        // sync_clear clears the sticky flag
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        chk1("clr_ovr", overrun, 1'b0);
        chk8("clr_dout", dout, 8'h00);
        chk1("clr_vld", dout_valid, 1'b0);

        // simultaneous handshake and completion
        dout_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_msbs(8'h5A, 8);
        chk8("sim_hold", dout, 8'h5A);
        exp_q.push_back(8'h0F);
        send_msbs(8'h0F, 7);
        chk8("sim_hold_7", dout, 8'h5A);
        dout_ready = 1'b1;
        send_bit(1'b1);
        chk8("sim_dout", dout, 8'h0F);
        chk1("sim_vld", dout_valid, 1'b1);
        chk1("sim_ovr", overrun, 1'b0);
        tick();
        chk1("sim_drain", dout_valid, 1'b0);

        // sync_clear mid-word with a coincident valid bit
        send_msbs(8'hB0, 5);
        sync_clear = 1'b1;
        din        = 1'b1;
        din_valid  = 1'b1;
        tick();
        sync_clear = 1'b0;
        din_valid  = 1'b0;
        chk1("mid_clr_vld", dout_valid, 1'b0);
        chk8("mid_clr_dout", dout, 8'h00);
        exp_q.push_back(8'hFF);
        send_word_chk(8'hFF, 0);
        chk8("mid_clr_word", dout, 8'hFF);
        tick();

        // async reset while FULL with overrun
        dout_ready = 1'b0;
        send_msbs(8'h5A, 8);
        send_msbs(8'hC3, 8);
        chk1("pre_rst_ovr", overrun, 1'b1);
        chk1("pre_rst_vld", dout_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_vld", dout_valid, 1'b0);
        chk1("arst_ovr", overrun, 1'b0);
        chk8("arst_dout", dout, 8'h00);
        tick();
        rst_n = 1'b1;
        dout_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_word_chk(8'h3C, 0);
        chk8("post_rst_word", dout, 8'h3C);
        tick();

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL sb_leftover: observed %0d queued expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
